multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM that sequences the RV32I fetch/decode/execute datapath around the instruction decoder. It requests instructions, loads the instruction register, and checks that the decoded opcode/funct3/funct7 form a legal instruction. It then steps each instruction through EXEC, MEM and WB, driving PC, register-file, ALU, immediate and data-memory controls. It covers R-type, I-type ALU, LOAD, STORE and BRANCH; anything else traps.

## Interface
- WIDTH, from all_pkgs (32): instruction width; not overridden here.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  decoder opcode (instr[6:0] of IR)
- funct3  in  3  decoder funct3
- funct7  in  7  decoder funct7
- rd  in  5  decoder rd
- imem_ack  in  1  instruction memory accepted req; IR data valid this cycle
- dmem_ack  in  1  data memory completed access this cycle
- branch_taken  in  1  ALU compare result, valid in EXEC
- imem_req  out  1  instruction fetch request
- ir_we  out  1  IR load strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  1  0 = PC+4, 1 = branch target
- imm_sel  out  2  0 = I, 1 = S, 2 = B
- alu_src_imm  out  1  ALU operand B = immediate
- alu_op  out  2  0 = ADD, 1 = FUNCT (from funct3/funct7), 2 = CMP
- dmem_req  out  1  data access request
- dmem_we  out  1  store when 1
- rf_we  out  1  register write strobe
- wb_sel  out  1  0 = ALU, 1 = memory data
- illegal  out  1  pulse in DECODE on illegal encoding
- halted  out  1  high while in TRAP
- instret  out  32  retired-instruction count (see Configuration)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset enters IDLE.
- **IDLE**: all outputs 0. Goes to FETCH unconditionally on the next edge.
- **FETCH**: imem_req=1. It holds until imem_ack and is never withdrawn early.
  - On imem_ack: ir_we=1 in that same cycle, then go to DECODE.
- **DECODE**: run the legality check.
  - Legal: go to EXEC.
  - Illegal: illegal=1 for this cycle, then go to TRAP.
- Legality rules:
  - R-type (0110011): funct7 must be 0000000, or 0100000 with funct3 000/101.
  - I-ALU (0010011): funct3 001 requires funct7 0000000; funct3 101 requires funct7 0000000 or 0100000.
  - LOAD (0000011): funct3 must be one of 000, 001, 010, 100, 101.
  - STORE (0100011): funct3 must be one of 000, 001, 010.
  - BRANCH (1100011): funct3 must not be 010 or 011.
  - Any other opcode is illegal.
- **EXEC**:
  - R-type: alu_op=FUNCT, then WB.
  - I-ALU: alu_op=FUNCT, alu_src_imm=1, imm_sel=I, then WB.
  - LOAD: alu_op=ADD, alu_src_imm=1, imm_sel=I, then MEM.
  - STORE: alu_op=ADD, alu_src_imm=1, imm_sel=S, then MEM.
  - BRANCH: alu_op=CMP, imm_sel=B, pc_we=1, pc_sel=branch_taken, then FETCH.
- **MEM**: dmem_req=1, with dmem_we=1 for STORE. It holds until dmem_ack.
  - LOAD on ack: go to WB.
  - STORE on ack: pc_we=1, pc_sel=0, then FETCH.
- **WB**: rf_we=(rd!=0), wb_sel=1 for LOAD else 0, pc_we=1, pc_sel=0, then FETCH.
- **TRAP**: halted=1, every other output 0. Exit only by reset.
- Outputs are combinational from state, plus imem_ack/dmem_ack/branch_taken. Any output not listed for a state is 0.

## Timing
- With zero-wait memories, state cycles per instruction:
  - R-type and I-ALU: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH: 3
- Each wait cycle (ack low) adds exactly one cycle in FETCH or MEM.
- An ack arriving in the same cycle the request is first raised is valid.
- opcode/funct3/funct7/rd come from the IR. They must stay stable from DECODE until the cycle of pc_we, and only ir_we in FETCH changes them.
- Exactly one pc_we pulse per retired instruction. None for an illegal instruction.
- Reset mid-operation:
  - Outputs go to 0 asynchronously.
  - Any pending imem/dmem request is dropped.
  - Resume from IDLE on the first edge after rst_n rises.
- Acks are ignored in states that do not request them.

## Configuration
- MULTICYCLE_CTRL_PERF_EN defined:
  - instret is a 32-bit register, reset 0.
  - It increments on every cycle with pc_we=1 and wraps 0xFFFFFFFF→0.
- MULTICYCLE_CTRL_PERF_EN not defined: the instret port exists but is tied to 0, and no counter is built.

## Structure
- In all_pkgs:
  - ctrl_state_t enum
  - alu_op_t and imm_sel_t enums
  - opcode localparams: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH
- One sub-module: instr_legal_chk. It is combinational, takes opcode/funct3/funct7 and outputs legal, and is instantiated once.

## Test plan
- Reset, then release with imem_ack held at 1 → IDLE 1 cycle, then imem_req=1 in cycle 2 with ir_we=1 in the same cycle.
- ADD x3 (opcode 0110011, f3 000, f7 0, rd 3), zero-wait → rf_we=1 on cycle 4, pc_we=1/pc_sel=0 in the same cycle, instret=1.
- LW rd=5, dmem_ack delayed 3 cycles → dmem_req held 4 cycles; WB has wb_sel=1 and rf_we=1; 8 cycles total.
- BEQ with branch_taken=1 → pc_we=1 and pc_sel=1 in EXEC (cycle 3); rf_we never asserted.
- Opcode 0110011 with f7 0100000, f3 001 → illegal pulses 1 cycle, then halted=1 with no pc_we. Reset clears halted to 0.
- ADDI with rd=0 → rf_we=0 in WB but pc_we=1. Assert rst_n low during MEM of a store → dmem_req drops immediately.

Source files
------------

// File: rtl/all_pkgs.sv
// rtl/all_pkgs.sv - shared types and constants for the multi-cycle RV32I controller
//
// Contents:
//   WIDTH          instruction / counter width (32)
//   OP_*           RV32I major opcodes handled by the controller
//   ctrl_state_t   controller FSM states
//   alu_op_t       ALU operation select driven on alu_op
//   imm_sel_t      immediate format select driven on imm_sel
package all_pkgs;

  localparam int WIDTH = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_FUNCT = 2'd1,
    ALU_CMP   = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2
  } imm_sel_t;

endpackage

// File: rtl/instr_legal_chk.sv
// rtl/instr_legal_chk.sv - combinational legality check of a decoded RV32I encoding
//
// Ports:
//   opcode  in  7  decoded opcode
//   funct3  in  3  decoded funct3
//   funct7  in  7  decoded funct7
//   legal   out 1  encoding is one the controller can sequence
module instr_legal_chk
  import all_pkgs::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      // Only ADD/SUB and SRL/SRA have a funct7=0100000 variant.
      OP_R: legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      // funct7 only matters for the shift-immediate forms.
      OP_IMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      end
      OP_LOAD: legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
      OP_STORE: legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      OP_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for RV32I
//
// Optional feature: define MULTICYCLE_CTRL_PERF_EN to build the instret counter;
// otherwise instret is tied to 0.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   opcode/funct3/funct7/rd    fields of the instruction register
//   imem_ack                   fetch accepted, IR data valid this cycle
//   dmem_ack                   data access completed this cycle
//   branch_taken               ALU compare result (used in EXEC)
//   imem_req, ir_we            fetch request, IR load strobe
//   pc_we, pc_sel              PC update strobe, 0 = PC+4 / 1 = branch target
//   imm_sel, alu_src_imm       immediate format, ALU operand B = immediate
//   alu_op                     0 = ADD, 1 = FUNCT, 2 = CMP
//   dmem_req, dmem_we          data access request, store
//   rf_we, wb_sel              register write strobe, 0 = ALU / 1 = memory data
//   illegal, halted            illegal-encoding pulse in DECODE, TRAP indication
//   instret                    retired-instruction count
module multicycle_ctrl
  import all_pkgs::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [4:0]       rd,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [1:0]       imm_sel,
  output logic             alu_src_imm,
  output logic [1:0]       alu_op,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             illegal,
  output logic             halted,
  output logic [WIDTH-1:0] instret
);

  ctrl_state_t state_q, state_d;
  logic        legal;

  instr_legal_chk u_legal (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .legal  (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The IR fields are held stable from DECODE until the pc_we cycle, so EXEC,
  // MEM and WB re-derive the instruction class from opcode instead of storing it.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    imm_sel     = IMM_I;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (legal) begin
          state_d = ST_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = ST_TRAP;
        end
      end

      ST_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op  = ALU_FUNCT;
            state_d = ST_WB;
          end
          OP_IMM: begin
            alu_op      = ALU_FUNCT;
            alu_src_imm = 1'b1;
            imm_sel     = IMM_I;
            state_d     = ST_WB;
          end
          OP_LOAD: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            imm_sel     = IMM_I;
            state_d     = ST_MEM;
          end
          OP_STORE: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            imm_sel     = IMM_S;
            state_d     = ST_MEM;
          end
          OP_BRANCH: begin
            alu_op  = ALU_CMP;
            imm_sel = IMM_B;
            pc_we   = 1'b1;
            pc_sel  = branch_taken;
            state_d = ST_FETCH;
          end
          // Unreachable while the IR is held stable; fail safe rather than run on.
          default: state_d = ST_TRAP;
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ack) begin
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        rf_we   = (rd != 5'd0);
        wb_sel  = (opcode == OP_LOAD);
        pc_we   = 1'b1;
        state_d = ST_FETCH;
      end

      ST_TRAP: halted = 1'b1;

      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [WIDTH-1:0] instret_q, instret_d;

  // One pc_we pulse per retired instruction; natural wrap at all-ones.
  always_comb instret_d = instret_q + {{(WIDTH-1){1'b0}}, pc_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard testbench for multicycle_ctrl
//
// Per-cycle stimulus and expected outputs are generated from the instruction
// sequencing table and pushed to queues; the driver pops one entry per cycle,
// applies the stimulus after the rising edge and compares on the falling edge.
// Define MULTICYCLE_CTRL_PERF_EN to also expect a live instret counter.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic [1:0] imm_sel;
    logic       alu_src_imm;
    logic [1:0] alu_op;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic       wb_sel;
    logic       illegal;
    logic       halted;
  } exp_t;

  typedef struct packed {
    logic       ia;
    logic       da;
    logic       br;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
  } stim_t;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rd = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req, ir_we, pc_we, pc_sel, alu_src_imm;
  logic [1:0]  imm_sel, alu_op;
  logic        dmem_req, dmem_we, rf_we, wb_sel, illegal, halted;
  logic [31:0] instret;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  string       tag_q[$];
  stim_t       stim_q[$];
  exp_t        exp_q[$];
  logic [31:0] inst_q[$];

  multicycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .rd           (rd),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .imm_sel      (imm_sel),
    .alu_src_imm  (alu_src_imm),
    .alu_op       (alu_op),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .halted       (halted),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_now();
    exp_t g;
    g.imem_req    = imem_req;
    g.ir_we       = ir_we;
    g.pc_we       = pc_we;
    g.pc_sel      = pc_sel;
    g.imm_sel     = imm_sel;
    g.alu_src_imm = alu_src_imm;
    g.alu_op      = alu_op;
    g.dmem_req    = dmem_req;
    g.dmem_we     = dmem_we;
    g.rf_we       = rf_we;
    g.wb_sel      = wb_sel;
    g.illegal     = illegal;
    g.halted      = halted;
    return {17'd0, g};
  endfunction

  task automatic push(input string tag, input stim_t s, input exp_t e);
    tag_q.push_back(tag);
    stim_q.push_back(s);
    exp_q.push_back(e);
`ifdef MULTICYCLE_CTRL_PERF_EN
    inst_q.push_back(32'(exp_cnt));
`else
    inst_q.push_back(32'd0);
`endif
    if (e.pc_we) exp_cnt++;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic gen_idle();
    stim_t s = '0;
    s.ia = 1'b1;
    s.da = 1'b1;
    push("IDLE", s, '0);
  endtask

  task automatic gen_trap(input int n);
    stim_t s = '0;
    exp_t  e = '0;
    s.ia = 1'b1;
    s.da = 1'b1;
    e.halted = 1'b1;
    for (int i = 0; i < n; i++) begin
      s.br = rbit();
      push("TRAP", s, e);
    end
  endtask

  task automatic gen(input string nm, input int kind, input logic [6:0] op,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] r,
                     input int fwait, input int mwait, input logic taken, input bit abort_mem);
    stim_t s;
    exp_t  e;
    s = '0;
    s.op = op; s.f3 = f3; s.f7 = f7; s.rd = r;
    for (int i = 0; i < fwait; i++) begin
      s.ia = 1'b0; s.da = rbit(); s.br = rbit();
      e = '0; e.imem_req = 1'b1;
      push({nm, ".FETCHW"}, s, e);
    end
    s.ia = 1'b1; s.da = rbit();
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
    push({nm, ".FETCH"}, s, e);
    s.ia = rbit(); s.da = rbit(); s.br = rbit();
    e = '0; e.illegal = (kind == K_ILL);
    push({nm, ".DECODE"}, s, e);
    if (kind == K_ILL) return;
    s.ia = rbit(); s.da = rbit();
    s.br = (kind == K_BR) ? taken : rbit();
    e = '0;
    case (kind)
      K_R:  e.alu_op = 2'd1;
      K_I:  begin e.alu_op = 2'd1; e.alu_src_imm = 1'b1; e.imm_sel = 2'd0; end
      K_LD: begin e.alu_op = 2'd0; e.alu_src_imm = 1'b1; e.imm_sel = 2'd0; end
      K_ST: begin e.alu_op = 2'd0; e.alu_src_imm = 1'b1; e.imm_sel = 2'd1; end
      default: begin e.alu_op = 2'd2; e.imm_sel = 2'd2; e.pc_we = 1'b1; e.pc_sel = taken; end
    endcase
    push({nm, ".EXEC"}, s, e);
    if (kind == K_BR) return;
    if (kind == K_LD || kind == K_ST) begin
      for (int i = 0; i < mwait; i++) begin
        s.da = 1'b0; s.ia = rbit(); s.br = rbit();
        e = '0; e.dmem_req = 1'b1; e.dmem_we = (kind == K_ST);
        push({nm, ".MEMW"}, s, e);
      end
      if (abort_mem) return;
      s.da = 1'b1; s.ia = rbit();
      e = '0; e.dmem_req = 1'b1; e.dmem_we = (kind == K_ST); e.pc_we = (kind == K_ST);
      push({nm, ".MEM"}, s, e);
      if (kind == K_ST) return;
    end
    s.ia = rbit(); s.da = rbit(); s.br = rbit();
    e = '0; e.rf_we = (r != 5'd0); e.wb_sel = (kind == K_LD); e.pc_we = 1'b1;
    push({nm, ".WB"}, s, e);
  endtask

  // Entered and left just after a rising edge.
  task automatic run_queue();
    while (exp_q.size() > 0) begin
      string tg;
      stim_t s;
      exp_t  e;
      logic [31:0] ei;
      tg = tag_q.pop_front();
      s  = stim_q.pop_front();
      e  = exp_q.pop_front();
      ei = inst_q.pop_front();
      imem_ack = s.ia; dmem_ack = s.da; branch_taken = s.br;
      opcode = s.op; funct3 = s.f3; funct7 = s.f7; rd = s.rd;
      @(negedge clk);
      check({tg, ".out"}, outs_now(), {17'd0, e});
      check({tg, ".instret"}, instret, ei);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.out", outs_now(), 32'd0);
    check("reset.instret", instret, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    imem_ack = 1'b1;
    do_reset();
    gen_idle();
    gen("add_x3", K_R,  7'b0110011, 3'b000, 7'b0000000, 5'd3, 0, 0, 1'b0, 1'b0);
    gen("lw_x5",  K_LD, 7'b0000011, 3'b010, 7'b0000000, 5'd5, 0, 3, 1'b0, 1'b0);
    gen("beq_t",  K_BR, 7'b1100011, 3'b000, 7'b0000000, 5'd9, 0, 0, 1'b1, 1'b0);
    gen("bne_nt", K_BR, 7'b1100011, 3'b001, 7'b0000000, 5'd0, 2, 0, 1'b0, 1'b0);
    gen("addi_0", K_I,  7'b0010011, 3'b000, 7'b0101010, 5'd0, 0, 0, 1'b0, 1'b0);
    gen("sw",     K_ST, 7'b0100011, 3'b010, 7'b0000000, 5'd4, 1, 1, 1'b0, 1'b0);
    gen("srai",   K_I,  7'b0010011, 3'b101, 7'b0100000, 5'd7, 0, 0, 1'b0, 1'b0);
    gen("sub",    K_R,  7'b0110011, 3'b000, 7'b0100000, 5'd31, 1, 0, 1'b0, 1'b0);
    gen("lhu",    K_LD, 7'b0000011, 3'b101, 7'b0000000, 5'd0, 0, 0, 1'b0, 1'b0);
    gen("bgeu",   K_BR, 7'b1100011, 3'b111, 7'b0000000, 5'd1, 0, 0, 1'b1, 1'b0);
    gen("r_ill",  K_ILL, 7'b0110011, 3'b001, 7'b0100000, 5'd2, 0, 0, 1'b0, 1'b0);
    gen_trap(4);
    run_queue();

    do_reset();
    gen_idle();
    gen("sb_abort", K_ST, 7'b0100011, 3'b000, 7'b0000000, 5'd6, 0, 2, 1'b0, 1'b1);
    run_queue();
    dmem_ack = 1'b0;
    #1;
    check("sb_abort.pre_dmem_req", 32'(dmem_req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("sb_abort.rst_dmem_req", 32'(dmem_req), 32'd0);
    check("sb_abort.rst_out", outs_now(), 32'd0);
    @(negedge clk);
    check("sb_abort.rst_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    gen_idle();
    gen("sll",    K_I,  7'b0010011, 3'b001, 7'b0000000, 5'd8, 0, 0, 1'b0, 1'b0);
    gen("sh",     K_ST, 7'b0100011, 3'b001, 7'b0000000, 5'd0, 0, 0, 1'b0, 1'b0);
    gen("ld_ill", K_ILL, 7'b0000011, 3'b011, 7'b0000000, 5'd3, 1, 0, 1'b0, 1'b0);
    gen_trap(2);
    run_queue();

    rst_n = 1'b0;
    #1;
    check("final.halted_cleared", 32'(halted), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
